// File: rtl/switch_debounce.sv
// DIP-switch conditioning: per-bit two-flop synchroniser plus stability-count debounce.
// Optional sticky change interrupt is built when SWDEB_IRQ_EN is defined.

module swdeb_lane #(
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic CLK_I,
    input  logic RST_I,
    input  logic raw,
    output logic deb,
    output logic upd
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;

    // High on the edge where the debounced value is about to take sync1.
    assign upd = (sync1 != deb) && (cnt == CNT_MAX);

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if (sync1 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                deb <= sync1;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

module switch_debounce #(
    parameter int WIDTH         = 32,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_W         = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] dipsw,
`ifdef SWDEB_IRQ_EN
    output logic             chg_o,
    output logic             INT_O,
    input  logic             INT_ACK_I
`else
    output logic             chg_o
`endif
);

    logic [WIDTH-1:0] upd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        swdeb_lane #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_lane (
            .CLK_I(CLK_I),
            .RST_I(RST_I),
            .raw  (sw_raw[i]),
            .deb  (dipsw[i]),
            .upd  (upd[i])
        );
    end

    // One pulse per updating edge regardless of how many bits move together.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) chg_o <= 1'b0;
        else        chg_o <= |upd;
    end

`ifdef SWDEB_IRQ_EN
    logic [WIDTH-1:0] chg_flag;
    logic [WIDTH-1:0] flag_nxt;

    // An ack wipes old flags but never loses a bit updating on the same edge.
    always_comb begin
        flag_nxt = INT_ACK_I ? upd : (chg_flag | upd);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            chg_flag <= '0;
            INT_O    <= 1'b0;
        end else begin
            chg_flag <= flag_nxt;
            INT_O    <= |flag_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with STABLE_CYCLES=4: stimulus pushes expected
// (edge, dipsw) pairs; the monitor checks them whenever chg_o pulses.

module tb_switch_debounce;

    localparam int W  = 32;
    localparam int SC = 4;

    logic         CLK_I;
    logic         RST_I;
    logic [W-1:0] sw_raw;
    logic [W-1:0] dipsw;
    logic         chg_o;
`ifdef SWDEB_IRQ_EN
    logic         INT_O;
    logic         INT_ACK_I;
`endif

    switch_debounce #(
        .WIDTH        (W),
        .STABLE_CYCLES(SC),
        .CNT_W        (16)
    ) dut (
        .CLK_I    (CLK_I),
        .RST_I    (RST_I),
        .sw_raw   (sw_raw),
        .dipsw    (dipsw),
`ifdef SWDEB_IRQ_EN
        .chg_o    (chg_o),
        .INT_O    (INT_O),
        .INT_ACK_I(INT_ACK_I)
`else
        .chg_o    (chg_o)
`endif
    );

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    always @(posedge CLK_I) cyc <= cyc + 1;

    // Monitor: every chg_o pulse must match the oldest expected update, value and edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK_I);
            if (chg_o) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL chg_unexpected: edge %0d dipsw=%h, no update expected", cyc, dipsw);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.val != dipsw) begin
                        n_err++;
                        $display("FAIL chg_update: edge %0d dipsw=%h, required edge %0d dipsw=%h",
                                 cyc, dipsw, e.cyc, e.val);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK_I);
    endtask

    // Called at a negedge: the value is captured at edge cyc+1 and lands SC+1 edges later.
    task automatic drive(input logic [W-1:0] v, input bit expect_upd);
        sw_raw = v;
        if (expect_upd) exp_q.push_back('{cyc + 2 + SC, v});
    endtask

    initial begin
        RST_I  = 1'b0;
        sw_raw = 32'hFFFF_FFFF;
`ifdef SWDEB_IRQ_EN
        INT_ACK_I = 1'b0;
`endif
        step(3);
        chk("reset_dipsw", dipsw, '0);
        chk("reset_chg", {31'b0, chg_o}, '0);

        // Release with pins all ones: update at edge 6 after release.
        RST_I = 1'b1;
        exp_q.push_back('{cyc + 2 + SC, 32'hFFFF_FFFF});
        step(10);
        chk("release_dipsw", dipsw, 32'hFFFF_FFFF);

        drive(32'h0, 1'b1);
        step(10);
        drive(32'h0000_0008, 1'b1);
        step(10);
        chk("toggle_dipsw", dipsw, 32'h0000_0008);

        // Three-cycle glitch on bit 0 must be swallowed.
        drive(32'h0000_0009, 1'b0);
        step(3);
        drive(32'h0000_0008, 1'b0);
        step(10);
        chk("glitch_dipsw", dipsw, 32'h0000_0008);

        drive(32'h0, 1'b1);
        step(10);

        // Bit 7 bounces in 2-cycle runs, the last run settles high.
        for (int p = 0; p < 5; p++) begin
            drive((p % 2 == 0) ? 32'h80 : 32'h0, p == 4);
            step(2);
        end
        step(8);
        chk("bounce_dipsw", dipsw, 32'h0000_0080);

        drive(32'h8000_0001, 1'b1);
        step(10);
        chk("simul_dipsw", dipsw, 32'h8000_0001);

        // Reset two counts into a change; outputs clear asynchronously.
        drive(32'h7FFF_FFFE, 1'b0);
        repeat (4) @(posedge CLK_I);
        #2 RST_I = 1'b0;
        #1;
        chk("midrst_dipsw", dipsw, '0);
        chk("midrst_chg", {31'b0, chg_o}, '0);
        @(negedge CLK_I);
        RST_I = 1'b1;
        exp_q.push_back('{cyc + 2 + SC, 32'h7FFF_FFFE});
        step(4);
        chk("midrst_hold", dipsw, '0);
        step(6);
        chk("midrst_dipsw_after", dipsw, 32'h7FFF_FFFE);

`ifdef SWDEB_IRQ_EN
        INT_ACK_I = 1'b1;
        step(1);
        INT_ACK_I = 1'b0;
        chk("irq_ack_clear", {31'b0, INT_O}, '0);

        drive(32'h7FFF_FFDE, 1'b1);
        step(10);
        chk("irq_set", {31'b0, INT_O}, 32'h1);
        step(5);
        chk("irq_sticky", {31'b0, INT_O}, 32'h1);

        INT_ACK_I = 1'b1;
        step(1);
        INT_ACK_I = 1'b0;
        chk("irq_ack", {31'b0, INT_O}, '0);

        // Ack lands exactly on the bit-6 update edge (cyc+1+SC+1 from drive).
        drive(32'h7FFF_FF9E, 1'b1);
        step(1 + SC);
        INT_ACK_I = 1'b1;
        step(1);
        INT_ACK_I = 1'b0;
        chk("irq_coinc_int", {31'b0, INT_O}, 32'h1);
        chk("irq_coinc_flag", dut.chg_flag, 32'h0000_0040);
        step(4);
`endif

        step(4);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_updates: got %0d outstanding, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
